pipeline_stage_skid: RTL and testbench
======================================

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

Interface
REQ-001 Parameter DATA_W, default 160, payload width in bits (one full decode-to-execute bundle: opcode, rd, funct3, rs1, rs2, funct7, imm, rs1_data, rs2_data, pc).
REQ-002 Parameter CNT_W, default 32, width of the stall-cycle counter.
REQ-003 clk  input  1  single clock; all state updates on the falling edge, matching the existing pipeline registers.
REQ-004 rst_n  input  1  synchronous, active-low reset, sampled on the falling edge of clk.
REQ-005 in_valid  input  1  upstream offers in_data this cycle.
REQ-006 in_ready  output  1  stage can accept; combinational, equals (occupancy != 2) AND NOT flush.
REQ-007 in_data  input  DATA_W  upstream payload.
REQ-008 out_valid  output  1  out_data is valid; combinational, equals main_valid AND NOT flush.
REQ-009 out_ready  input  1  downstream accepts out_data this cycle.
REQ-010 out_data  output  DATA_W  payload of the oldest held entry (main register).
REQ-011 flush  input  1  discard all held entries (branch/jump redirect).
REQ-012 occupancy  output  2  number of held entries, 0..2, registered.
REQ-013 stall_cnt  output  CNT_W  count of cycles with output blocked, registered.

Function
REQ-014 Storage: main register (main_valid, main_data) and skid register (skid_valid, skid_data); occupancy 0 = EMPTY, 1 = ONE (main only), 2 = TWO (main + skid); skid_valid=1 never occurs with main_valid=0.
REQ-015 in_fire = in_valid AND in_ready; out_fire = out_valid AND out_ready; both evaluated just before the falling edge.
REQ-016 EMPTY: in_fire -> main_data <= in_data, ONE; else stay EMPTY.
REQ-017 ONE: in_fire AND out_fire -> main_data <= in_data, stay ONE; in_fire only -> skid_data <= in_data, TWO; out_fire only -> EMPTY; neither -> hold.
REQ-018 TWO: in_ready = 0; out_fire -> main_data <= skid_data, ONE; else hold.
REQ-019 Latency: word accepted at falling edge N is presented on out_data after edge N when entering EMPTY->ONE; sustained throughput 1 word per cycle with out_ready held high.
REQ-020 Ordering: words leave in exact acceptance order; no word duplicated or dropped except by flush or reset.
REQ-021 Backpressure: out_data and out_valid stable while out_valid=1 and out_ready=0 (no flush).
REQ-022 flush=1 at a falling edge: main_valid, skid_valid <= 0, main_data, skid_data <= 0, occupancy <= 0; in_ready and out_valid forced 0 during that cycle, so no transfer occurs in either direction.
REQ-023 flush has priority over every other event, including simultaneous in_valid and out_ready.
REQ-024 stall_cnt increments by 1 at each falling edge where out_valid=1 and out_ready=0; saturates at 2^CNT_W-1; not cleared by flush.
REQ-025 out_data equals 0 whenever out_valid=0 due to empty state.

Reset
REQ-026 rst_n=0 at a falling edge: main_valid, skid_valid <= 0, main_data, skid_data <= 0, occupancy <= 0, stall_cnt <= 0.
REQ-027 Reset has priority over flush and all handshakes; a word mid-transfer at reset is discarded.
REQ-028 After reset released: in_ready=1, out_valid=0, out_data=0, stall_cnt=0.

Verification
REQ-029 Stream: out_ready=1, send 0x1,0x2,0x3 on consecutive edges -> outputs 0x1,0x2,0x3 one edge later each, occupancy stays 1, stall_cnt=0.
REQ-030 Backpressure: out_ready=0, send 0xA then 0xB -> occupancy 2, in_ready=0, 0xC held off; raise out_ready -> 0xA, 0xB, 0xC delivered in order, stall_cnt equals blocked cycle count.
REQ-031 Flush in TWO with in_valid=1 and out_ready=1 -> next cycle occupancy 0, out_valid=0, out_data=0, no word consumed or delivered; stall_cnt unchanged.
REQ-032 Reset in TWO with stall_cnt=5 -> occupancy 0, stall_cnt 0, in_ready 1 after the edge.
REQ-033 Saturation with CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays 15.
REQ-034 Random valid/ready (10k cycles, scoreboard) -> no loss, duplication or reorder; REQ-021 stability holds every cycle.

Source files
------------

// File: rtl/pipeline_stage_skid.sv
// Decode-to-execute pipeline stage with a two-entry skid buffer.
// A main register presents the oldest word; a skid register catches one extra
// word when the consumer stalls, so in_ready can be derived from registered
// occupancy alone rather than from out_ready combinationally.
// All state changes on the falling edge of clk, matching the surrounding
// pipeline registers. Reset is synchronous and active low.
module pipeline_stage_skid #(
    parameter int DATA_W = 160,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Occupancy doubles as the state encoding: EMPTY, main only, main + skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t            state_reg;
    logic [DATA_W-1:0] main_data_reg;
    logic [DATA_W-1:0] skid_data_reg;
    logic [CNT_W-1:0]  stall_cnt_reg;
    logic [CNT_W-1:0]  stall_cnt_next;

    logic main_valid;
    logic skid_valid;
    logic in_fire;
    logic out_fire;
    logic out_blocked;

    // Valid flags follow directly from the state, so skid can never be valid
    // without main.
    assign main_valid = (state_reg != ST_EMPTY);
    assign skid_valid = (state_reg == ST_TWO);

    // Flush masks both handshakes so nothing transfers during a redirect.
    assign in_ready    = !skid_valid && !flush;
    assign out_valid   = main_valid && !flush;
    assign in_fire     = in_valid && in_ready;
    assign out_fire    = out_valid && out_ready;
    assign out_blocked = out_valid && !out_ready;

    assign occupancy = state_reg;
    assign stall_cnt = stall_cnt_reg;

    // Present zero on the data bus whenever the stage holds nothing.
    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_out_gate
            assign out_data[gi] = main_data_reg[gi] & main_valid;
        end
    endgenerate

    // Saturating count of cycles where the consumer refused a valid word.
    always_comb begin
        stall_cnt_next = stall_cnt_reg;
        if (out_blocked && (stall_cnt_reg != CNT_MAX)) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
    end

    // Skid buffer state machine and storage; reset beats flush beats handshakes.
    always_ff @(negedge clk) begin
        if (!rst_n) begin
            state_reg     <= ST_EMPTY;
            main_data_reg <= '0;
            skid_data_reg <= '0;
            stall_cnt_reg <= '0;
        end else begin
            // Stall history survives a flush; it is a performance counter.
            stall_cnt_reg <= stall_cnt_next;
            if (flush) begin
                state_reg     <= ST_EMPTY;
                main_data_reg <= '0;
                skid_data_reg <= '0;
            end else begin
                case (state_reg)
                    ST_EMPTY: begin
                        if (in_fire) begin
                            main_data_reg <= in_data;
                            state_reg     <= ST_ONE;
                        end
                    end
                    ST_ONE: begin
                        if (in_fire && out_fire) begin
                            main_data_reg <= in_data;
                        end else if (in_fire) begin
                            skid_data_reg <= in_data;
                            state_reg     <= ST_TWO;
                        end else if (out_fire) begin
                            main_data_reg <= '0;
                            state_reg     <= ST_EMPTY;
                        end
                    end
                    ST_TWO: begin
                        // in_ready is low here, so only the drain can happen.
                        if (out_fire) begin
                            main_data_reg <= skid_data_reg;
                            skid_data_reg <= '0;
                            state_reg     <= ST_ONE;
                        end
                    end
                    default: begin
                        state_reg     <= ST_EMPTY;
                        main_data_reg <= '0;
                        skid_data_reg <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed and randomized checks for the skid-buffered pipeline stage.
// The DUT updates on the falling edge; the bench drives inputs 1 time unit
// after each falling edge and samples 1 unit after driving, or after the edge.
module tb_pipeline_stage_skid;

    localparam int DW = 160;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid, in_ready, out_valid, out_ready, flush;
    logic [DW-1:0] in_data, out_data;
    logic [1:0]    occupancy;
    logic [31:0]   stall_cnt;

    logic          in_valid4, in_ready4, out_valid4, out_ready4, flush4;
    logic [DW-1:0] in_data4, out_data4;
    logic [1:0]    occupancy4;
    logic [3:0]    stall_cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pipeline_stage_skid #(.DATA_W(DW), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .occupancy(occupancy), .stall_cnt(stall_cnt)
    );

    pipeline_stage_skid #(.DATA_W(DW), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .flush(flush4), .occupancy(occupancy4), .stall_cnt(stall_cnt4)
    );

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [DW-1:0] d, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
    endtask

    // Expect a full set of registered/combinational outputs after settling.
    task automatic expect_state(input string tag, input logic [1:0] occ, input logic ov,
                                input logic [DW-1:0] od, input logic [31:0] sc);
        checks++;
        if (occupancy !== occ) begin
            failures++; $display("FAIL %s occupancy actual=%0d expected=%0d", tag, occupancy, occ);
        end
        checks++;
        if (out_valid !== ov) begin
            failures++; $display("FAIL %s out_valid actual=%0b expected=%0b", tag, out_valid, ov);
        end
        checks++;
        if (out_data !== od) begin
            failures++; $display("FAIL %s out_data actual=%0h expected=%0h", tag, out_data, od);
        end
        checks++;
        if (stall_cnt !== sc) begin
            failures++; $display("FAIL %s stall_cnt actual=%0d expected=%0d", tag, stall_cnt, sc);
        end
    endtask

    task automatic test_reset();
        in_valid4 = 0; in_data4 = '0; out_ready4 = 0; flush4 = 0;
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL reset in_ready actual=%0b expected=1", in_ready);
        end
        expect_state("reset", 2'd0, 1'b0, '0, 32'd0);
        $display("test_reset: done");
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, DW'(i), 1'b1, 1'b0);
            checks++;
            if (in_ready !== 1'b1) begin
                failures++; $display("FAIL stream in_ready word %0d actual=%0b expected=1", i, in_ready);
            end
            cyc();
            expect_state($sformatf("stream_w%0d", i), 2'd1, 1'b1, DW'(i), 32'd0);
            $display("test_stream: word 0x%0h presented", i);
        end
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        expect_state("stream_drain", 2'd0, 1'b0, '0, 32'd0);
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(1'b1, DW'(32'hA), 1'b0, 1'b0);
        cyc();
        expect_state("bp_a", 2'd1, 1'b1, DW'(32'hA), 32'd0);
        drive(1'b1, DW'(32'hB), 1'b0, 1'b0);
        cyc();
        expect_state("bp_b", 2'd2, 1'b1, DW'(32'hA), 32'd1);
        drive(1'b1, DW'(32'hC), 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_full in_ready actual=%0b expected=0", in_ready);
        end
        cyc();
        expect_state("bp_hold", 2'd2, 1'b1, DW'(32'hA), 32'd2);
        // Release: A leaves, C still refused because skid is full this cycle.
        drive(1'b1, DW'(32'hC), 1'b1, 1'b0);
        checks++;
        if (in_ready !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready actual=%0b expected=0", in_ready);
        end
        cyc();
        expect_state("bp_out_a", 2'd1, 1'b1, DW'(32'hB), 32'd2);
        drive(1'b1, DW'(32'hC), 1'b1, 1'b0);
        cyc();
        expect_state("bp_out_b", 2'd1, 1'b1, DW'(32'hC), 32'd2);
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc();
        expect_state("bp_out_c", 2'd0, 1'b0, '0, 32'd2);
        $display("test_backpressure: A,B,C delivered, stalls=2");
    endtask

    task automatic test_flush();
        do_reset();
        drive(1'b1, DW'(32'hA), 1'b0, 1'b0);
        cyc();
        drive(1'b1, DW'(32'hB), 1'b0, 1'b0);
        cyc();
        expect_state("fl_pre", 2'd2, 1'b1, DW'(32'hA), 32'd1);
        drive(1'b1, DW'(32'hC), 1'b1, 1'b1);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL fl_mask in_ready=%0b out_valid=%0b expected 0/0", in_ready, out_valid);
        end
        cyc();
        drive(1'b0, '0, 1'b1, 1'b0);
        expect_state("fl_post", 2'd0, 1'b0, '0, 32'd1);
        cyc();
        expect_state("fl_idle", 2'd0, 1'b0, '0, 32'd1);
        drive(1'b1, DW'(32'hD), 1'b0, 1'b0);
        cyc();
        expect_state("fl_next", 2'd1, 1'b1, DW'(32'hD), 32'd1);
        $display("test_flush: TWO flushed, C not consumed");
    endtask

    task automatic test_reset_in_two();
        do_reset();
        drive(1'b1, DW'(32'hA), 1'b0, 1'b0);
        cyc();
        drive(1'b1, DW'(32'hB), 1'b0, 1'b0);
        cyc();
        drive(1'b0, '0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        expect_state("rst2_pre", 2'd2, 1'b1, DW'(32'hA), 32'd5);
        rst_n = 1'b0;
        drive(1'b1, DW'(32'hC), 1'b1, 1'b1);
        cyc();
        rst_n = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0);
        expect_state("rst2_post", 2'd0, 1'b0, '0, 32'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++; $display("FAIL rst2 in_ready actual=%0b expected=1", in_ready);
        end
        $display("test_reset_in_two: cleared");
    endtask

    task automatic test_saturation();
        do_reset();
        in_valid4 = 1'b1; in_data4 = DW'(32'h55); out_ready4 = 1'b0; flush4 = 1'b0;
        cyc();
        in_valid4 = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            cyc();
            if (n == 14 || n == 15 || n == 20) begin
                checks++;
                if (stall_cnt4 !== ((n < 15) ? 4'(n) : 4'd15)) begin
                    failures++;
                    $display("FAIL sat_n%0d stall_cnt actual=%0d expected=%0d", n, stall_cnt4,
                             (n < 15) ? n : 15);
                end
                $display("test_saturation: after %0d blocked cycles stall_cnt=%0d", n, stall_cnt4);
            end
        end
        checks++;
        if (out_valid4 !== 1'b1 || out_data4 !== DW'(32'h55)) begin
            failures++;
            $display("FAIL sat_hold out_valid=%0b out_data=%0h expected 1/55", out_valid4, out_data4);
        end
    endtask

    task automatic test_random();
        logic [DW-1:0] q[$];
        logic [DW-1:0] exp_od, prev_data;
        logic          exp_ir, exp_ov, prev_blocked;
        logic [31:0]   exp_sc;
        int            seq, delivered;
        do_reset();
        exp_sc = 0; seq = 0; prev_blocked = 0; prev_data = '0; delivered = 0;
        for (int c = 0; c < 10000; c++) begin
            drive(1'($urandom_range(0, 1)), {DW'(seq) << 32} | DW'($urandom),
                  1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 99) == 0));
            exp_ir = (q.size() != 2) && !flush;
            exp_ov = (q.size() != 0) && !flush;
            exp_od = (q.size() != 0) ? q[0] : '0;
            checks++;
            if (in_ready !== exp_ir || out_valid !== exp_ov || out_data !== exp_od) begin
                failures++;
                $display("FAIL rnd_c%0d ir/ov/od actual=%0b/%0b/%0h expected=%0b/%0b/%0h", c,
                         in_ready, out_valid, out_data, exp_ir, exp_ov, exp_od);
            end
            if (prev_blocked && !flush) begin
                checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data) begin
                    failures++;
                    $display("FAIL rnd_stable_c%0d out_data actual=%0h expected=%0h", c, out_data, prev_data);
                end
            end
            prev_blocked = exp_ov && !out_ready;
            prev_data    = exp_od;
            if (exp_ov && !out_ready) exp_sc++;
            if (flush) begin
                q.delete();
            end else begin
                if (exp_ov && out_ready) begin
                    void'(q.pop_front());
                    delivered++;
                end
                if (exp_ir && in_valid) begin
                    q.push_back(in_data);
                    seq++;
                end
            end
            cyc();
            checks++;
            if (occupancy !== 2'(q.size()) || stall_cnt !== exp_sc) begin
                failures++;
                $display("FAIL rnd_reg_c%0d occ/stall actual=%0d/%0d expected=%0d/%0d", c,
                         occupancy, stall_cnt, q.size(), exp_sc);
            end
        end
        $display("test_random: accepted=%0d delivered=%0d stalls=%0d", seq, delivered, exp_sc);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 0; in_data = '0; out_ready = 0; flush = 0;
        in_valid4 = 0; in_data4 = '0; out_ready4 = 0; flush4 = 0;
        #2;
        test_reset();
        test_stream();
        test_backpressure();
        test_flush();
        test_reset_in_two();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
